// File: rtl/phase_input_stage.sv
// rtl/phase_input_stage.sv - sensor sync/debounce, pedestrian latch and per-phase expiry timer
// Sits in front of the traffic-phase controller and produces its L, P and T inputs.
// Optional build macro: PHASE_GREEN_EXT_EN (one green extension while L is high).
module phase_input_stage #(
  parameter int DEBOUNCE    = 4,
  parameter int TW          = 8,
  parameter int GREEN_N     = 20,
  parameter int YELLOW_N    = 4,
  parameter int RED_N       = 16,
  parameter int GREEN_EXT_N = 10
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          L_RAW,
  input  logic          P_RAW,
  input  logic          G,
  input  logic          Y,
  input  logic          R,
  output logic          L,
  output logic          P,
  output logic          T,
  output logic [TW-1:0] CNT
);

  // A duration of 0 would never expire, so it is promoted to 1.
  function automatic logic [TW-1:0] clamp_n(input int n);
    if (n <= 0) begin
      return TW'(1);
    end
    return TW'(n);
  endfunction

  localparam logic [TW-1:0] GREEN_LD     = clamp_n(GREEN_N);
  localparam logic [TW-1:0] YELLOW_LD    = clamp_n(YELLOW_N);
  localparam logic [TW-1:0] RED_LD       = clamp_n(RED_N);
  localparam logic [TW-1:0] GREEN_EXT_LD = clamp_n(GREEN_EXT_N);
  localparam logic [7:0]    DB_LIM       = 8'(DEBOUNCE);

  typedef enum logic [1:0] {
    PH_GRN,
    PH_YEL,
    PH_RED,
    PH_INV
  } phase_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // synchronizer and debounce state
  logic       l_meta, l_sync;
  logic       p_meta, p_sync;
  logic [7:0] l_cnt, p_cnt;
  logic       l_deb;
  logic       pb, pb_q;
  logic       p_req;

  // phase tracking and timer state
  phase_t        phase, prev;
  logic [TW-1:0] phase_load;
  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          t_q, t_d;
  logic          extend;

`ifdef PHASE_GREEN_EXT_EN
  logic ext_q, ext_d;
`endif

  // two-flop synchronizers for both asynchronous inputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      l_meta <= 1'b0;
      l_sync <= 1'b0;
      p_meta <= 1'b0;
      p_sync <= 1'b0;
    end else begin
      l_meta <= L_RAW;
      l_sync <= l_meta;
      p_meta <= P_RAW;
      p_sync <= p_meta;
    end
  end

  // lane debounce: toggle only after the sync value has disagreed long enough
  always_ff @(posedge CLK) begin
    if (RST) begin
      l_cnt <= '0;
      l_deb <= 1'b0;
    end else if (l_sync == l_deb) begin
      l_cnt <= '0;
    end else if (l_cnt == DB_LIM) begin
      l_deb <= ~l_deb;
      l_cnt <= '0;
    end else begin
      l_cnt <= l_cnt + 8'd1;
    end
  end

  // button debounce, same rule as the lane sensor
  always_ff @(posedge CLK) begin
    if (RST) begin
      p_cnt <= '0;
      pb    <= 1'b0;
    end else if (p_sync == pb) begin
      p_cnt <= '0;
    end else if (p_cnt == DB_LIM) begin
      pb    <= ~pb;
      p_cnt <= '0;
    end else begin
      p_cnt <= p_cnt + 8'd1;
    end
  end

  // pedestrian request: red clears it and wins over a new press edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      pb_q  <= 1'b0;
      p_req <= 1'b0;
    end else begin
      pb_q <= pb;
      if (R) begin
        p_req <= 1'b0;
      end else if (pb && !pb_q) begin
        p_req <= 1'b1;
      end
    end
  end

  // decode the controller's one-hot phase and pick its duration
  always_comb begin
    phase      = PH_INV;
    phase_load = '0;
    case ({G, Y, R})
      3'b100: begin
        phase      = PH_GRN;
        phase_load = GREEN_LD;
      end
      3'b010: begin
        phase      = PH_YEL;
        phase_load = YELLOW_LD;
      end
      3'b001: begin
        phase      = PH_RED;
        phase_load = RED_LD;
      end
      default: begin
        phase      = PH_INV;
        phase_load = '0;
      end
    endcase
  end

  // registered phase; starting at INV makes the first valid phase a change
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev <= PH_INV;
    end else begin
      prev <= phase;
    end
  end

`ifdef PHASE_GREEN_EXT_EN
  assign extend = (phase == PH_GRN) && l_deb && !ext_q;
`else
  assign extend = 1'b0;
`endif

  // timer state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      t_q     <= 1'b0;
`ifdef PHASE_GREEN_EXT_EN
      ext_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
`ifdef PHASE_GREEN_EXT_EN
      ext_q   <= ext_d;
`endif
    end
  end

  // timer next state: invalid phase, then phase change, then countdown
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = 1'b0;
`ifdef PHASE_GREEN_EXT_EN
    ext_d   = ext_q;
`endif
    if (phase == PH_INV) begin
      state_d = S_IDLE;
      cnt_d   = '0;
`ifdef PHASE_GREEN_EXT_EN
      ext_d   = 1'b0;
`endif
    end else if (phase != prev) begin
      state_d = S_RUN;
      cnt_d   = phase_load;
`ifdef PHASE_GREEN_EXT_EN
      ext_d   = 1'b0;
`endif
    end else if (state_q == S_RUN) begin
      if (cnt_q == TW'(1)) begin
        if (extend) begin
          cnt_d = GREEN_EXT_LD;
`ifdef PHASE_GREEN_EXT_EN
          ext_d = 1'b1;
`endif
        end else begin
          cnt_d   = '0;
          t_d     = 1'b1;
          state_d = S_DONE;
        end
      end else begin
        cnt_d = cnt_q - TW'(1);
      end
    end
  end

  // outputs straight from registers so T is a clean one-cycle pulse
  always_comb begin
    L   = l_deb;
    P   = p_req;
    T   = t_q;
    CNT = cnt_q;
  end

endmodule
